hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Parametrised successor to the pipeline's forwarding-only hazard logic. It is the full hazard controller for the 5-stage core.
- Execute-stage operand forwarding for NUM_SRC source operands.
- Multi-cycle load-use stall sequencing via a small FSM with a stall counter.
- Branch/jump flush generation.
- A saturating stall-cycle performance counter.
It sits beside the datapath and drives the F/D/E pipeline-register enables and clears plus the E-stage forwarding muxes.

Parameters:
REG_AW, 5, register-address width; register 0 is hardwired zero and is never forwarded or stalled on.
NUM_SRC, 2, source operands per instruction (2 for integer, 3 for fused ops); legal range 1..3.
LOAD_LAT, 1, number of bubble cycles a load-use dependency costs; legal range 1..3.
PERF_W, 16, width of the stall-cycle counter.

Ports:
clk  input  1  core clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
RegWriteM  input  1  M-stage instruction writes the register file.
RegWriteW  input  1  W-stage instruction writes the register file.
RDM  input  REG_AW  M-stage destination register.
RDW  input  REG_AW  W-stage destination register.
RDE  input  REG_AW  E-stage destination register.
LoadE  input  1  E-stage instruction is a load.
PCSrcE  input  1  branch or jump resolved taken in E.
RSD  input  NUM_SRC*REG_AW  D-stage source registers; operand i is at [i*REG_AW +: REG_AW].
SrcUsedD  input  NUM_SRC  per-operand valid for RSD.
RSE  input  NUM_SRC*REG_AW  E-stage source registers, packed the same way as RSD.
ForwardE  output  NUM_SRC*2  per-operand mux select at [i*2 +: 2]: 00 = regfile, 10 = M result, 01 = W result.
StallF  output  1  hold the PC.
StallD  output  1  hold the F/D register.
FlushD  output  1  clear the F/D register.
FlushE  output  1  clear the D/E register (insert bubble).
stall_cycles  output  PERF_W  saturating count of cycles with StallD=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, stall_cycles=0.
  - While reset=0, ForwardE=0, StallF=StallD=FlushD=FlushE=0.
- Forwarding (combinational, per operand i):
  - 10 if RegWriteM && RDM!=0 && RDM==RSE[i].
  - Else 01 if RegWriteW && RDW!=0 && RDW==RSE[i].
  - Else 00.
  - M has priority over W. Forwarding is independent of FSM state.
- Load-use detect (combinational): luse = LoadE && RDE!=0 && any i with SrcUsedD[i] && RSD[i]==RDE.
- FSM states: IDLE, STALL. cnt is 2 bits.
- IDLE:
  - If PCSrcE: FlushD=1, FlushE=1, no stall, stay IDLE. Branch wins over luse because the dependent D instruction is discarded.
  - Else if luse: StallF=StallD=FlushE=1 this cycle. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1; otherwise stay IDLE.
  - Else all control outputs are 0.
- STALL:
  - StallF=StallD=FlushE=1 every cycle.
  - cnt decrements each cycle; when cnt==1, return to IDLE next edge.
  - Total bubble cycles per load-use = LOAD_LAT exactly.
  - luse is not re-evaluated in STALL, because E holds a bubble.
- PCSrcE while in STALL (abnormal, but defined): FlushD=FlushE=1, StallF=StallD=0, go to IDLE, cnt=0.
- After returning to IDLE, luse is evaluated normally. A back-to-back dependent load is stalled again.
- stall_cycles increments on every edge where StallD=1. It holds at 2^PERF_W-1 (no wrap).
- Reset deasserted mid-stall is not a case; reset asserted mid-stall aborts to IDLE immediately.
- Outputs other than stall_cycles are combinational from state, cnt and inputs. There is no added latency.

Test Plan:
1. Forward priority: RegWriteM=RegWriteW=1, RDM=RDW=5, RSE op0=5, op1=6 → ForwardE op0=10, op1=00. Then RegWriteM=0 → op0=01. Then RDM=RDW=0, RSE op0=0 → 00.
2. Load-use, LOAD_LAT=1: LoadE=1, RDE=7, RSD op1=7, SrcUsedD=2'b10 → StallF=StallD=FlushE=1 for exactly 1 cycle, stall_cycles 0→1. Repeat with SrcUsedD=2'b01 → no stall.
3. Load-use, LOAD_LAT=3 → stall asserted for exactly 3 consecutive cycles and FSM back in IDLE. Inject PCSrcE=1 in the 2nd stall cycle → FlushD=FlushE=1, StallD=0 that cycle, IDLE next, stall_cycles=+1 only.
4. Simultaneous luse and PCSrcE in IDLE → FlushD=FlushE=1, StallF=StallD=0, stall_cycles unchanged.
5. Saturation: PERF_W=4, hold repeated load-use for 20 stall cycles → stall_cycles reaches 15 and stays at 15.
6. Async reset: assert reset=0 mid-STALL between clock edges → stall/flush/forward outputs drop to 0 immediately and stall_cycles=0. Release reset → IDLE, normal operation on the next luse.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: E-stage operand forwarding, load-use
// stall sequencing, branch/jump flushes and a saturating stall-cycle counter.
module hazard_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        RegWriteM,
    input  logic                        RegWriteW,
    input  logic [REG_AW-1:0]           RDM,
    input  logic [REG_AW-1:0]           RDW,
    input  logic [REG_AW-1:0]           RDE,
    input  logic                        LoadE,
    input  logic                        PCSrcE,
    input  logic [NUM_SRC*REG_AW-1:0]   RSD,
    input  logic [NUM_SRC-1:0]          SrcUsedD,
    input  logic [NUM_SRC*REG_AW-1:0]   RSE,
    output logic [NUM_SRC*2-1:0]        ForwardE,
    output logic                        StallF,
    output logic                        StallD,
    output logic                        FlushD,
    output logic                        FlushE,
    output logic [PERF_W-1:0]           stall_cycles
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0]        CNT_INIT = 2'(LOAD_LAT - 1);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;
    localparam logic [PERF_W-1:0] PERF_ONE = 1;

    state_t              r_state;
    logic [1:0]          r_cnt;
    logic [PERF_W-1:0]   r_stallCycles;

    logic [NUM_SRC*2-1:0] w_forward;
    logic                 w_luse;
    logic                 w_stall;
    logic                 w_flushD;
    logic                 w_flushE;

    // M-stage results win over W because they are the younger write.
    always_comb begin
        w_forward = '0;
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (RegWriteM && (RDM != '0) && (RDM == RSE[i*REG_AW +: REG_AW]))
                    w_forward[i*2 +: 2] = 2'b10;
                else if (RegWriteW && (RDW != '0) && (RDW == RSE[i*REG_AW +: REG_AW]))
                    w_forward[i*2 +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        w_luse = 1'b0;
        if (LoadE && (RDE != '0)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (SrcUsedD[i] && (RSD[i*REG_AW +: REG_AW] == RDE))
                    w_luse = 1'b1;
            end
        end
    end

    // A taken branch discards the dependent D instruction, so it beats any stall.
    always_comb begin
        w_stall  = 1'b0;
        w_flushD = 1'b0;
        w_flushE = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    if (PCSrcE) begin
                        w_flushD = 1'b1;
                        w_flushE = 1'b1;
                    end else if (w_luse) begin
                        w_stall  = 1'b1;
                        w_flushE = 1'b1;
                    end
                end
                STALL: begin
                    if (PCSrcE) begin
                        w_flushD = 1'b1;
                        w_flushE = 1'b1;
                    end else begin
                        w_stall  = 1'b1;
                        w_flushE = 1'b1;
                    end
                end
                default: begin
                    w_stall  = 1'b0;
                    w_flushD = 1'b0;
                    w_flushE = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= 2'd0;
            r_stallCycles <= '0;
        end else begin
            if (w_stall && (r_stallCycles != PERF_MAX))
                r_stallCycles <= r_stallCycles + PERF_ONE;
            case (r_state)
                IDLE: begin
                    if (!PCSrcE && w_luse && (LOAD_LAT > 1)) begin
                        r_state <= STALL;
                        r_cnt   <= CNT_INIT;
                    end
                end
                STALL: begin
                    if (PCSrcE || (r_cnt == 2'd1)) begin
                        r_state <= IDLE;
                        r_cnt   <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 2'd0;
                end
            endcase
        end
    end

    assign ForwardE     = w_forward;
    assign StallF       = w_stall;
    assign StallD       = w_stall;
    assign FlushD       = w_flushD;
    assign FlushE       = w_flushE;
    assign stall_cycles = r_stallCycles;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: one instance with LOAD_LAT=1/PERF_W=4 and
// one with LOAD_LAT=3/PERF_W=16, both driven from the same stimulus.
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, RegWriteW;
    logic [4:0]  RDM, RDW, RDE;
    logic        LoadE, PCSrcE;
    logic [9:0]  RSD, RSE;
    logic [1:0]  SrcUsedD;

    logic [3:0]  ForwardE1, ForwardE3;
    logic        StallF1, StallD1, FlushD1, FlushE1;
    logic        StallF3, StallD3, FlushD3, FlushE3;
    logic [3:0]  stallCycles1;
    logic [15:0] stallCycles3;

    int testsRun;
    int testsFailed;

    hazard_ctrl_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .PERF_W(4)) u_lat1 (
        .clk(clk), .reset(reset), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RDM(RDM), .RDW(RDW), .RDE(RDE), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .RSD(RSD), .SrcUsedD(SrcUsedD), .RSE(RSE), .ForwardE(ForwardE1),
        .StallF(StallF1), .StallD(StallD1), .FlushD(FlushD1), .FlushE(FlushE1),
        .stall_cycles(stallCycles1)
    );

    hazard_ctrl_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .PERF_W(16)) u_lat3 (
        .clk(clk), .reset(reset), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RDM(RDM), .RDW(RDW), .RDE(RDE), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .RSD(RSD), .SrcUsedD(SrcUsedD), .RSE(RSE), .ForwardE(ForwardE3),
        .StallF(StallF3), .StallD(StallD3), .FlushD(FlushD3), .FlushE(FlushE3),
        .stall_cycles(stallCycles3)
    );

    always #5 clk = ~clk;

    // Control outputs are compared as {StallF, StallD, FlushD, FlushE}.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rwM, input logic rwW, input logic [4:0] rdM,
                                 input logic [4:0] rdW, input logic [4:0] rdE,
                                 input logic ld, input logic br, input logic [9:0] rsd,
                                 input logic [1:0] used, input logic [9:0] rse);
        RegWriteM = rwM;
        RegWriteW = rwW;
        RDM       = rdM;
        RDW       = rdW;
        RDE       = rdE;
        LoadE     = ld;
        PCSrcE    = br;
        RSD       = rsd;
        SrcUsedD  = used;
        RSE       = rse;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Load in E writes r7, D reads r7 on operand 1 and r3 on operand 0.
    task automatic applyLoadUse(input logic br);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, br, {5'd7, 5'd3}, 2'b10, 10'd0);
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 10'd0, 2'b00, 10'd0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        // Reset held: a would-be M forward must stay masked.
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 10'd0, 2'b00, {5'd0, 5'd5});
        #3;
        checkOutput("reset fwd", ForwardE1, 4'b0000);
        checkOutput("reset ctrl", {StallF1, StallD1, FlushD1, FlushE1}, 4'b0000);
        checkOutput("reset cnt1", stallCycles1, 0);
        checkOutput("reset cnt3", stallCycles3, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Forwarding priority and register-zero exclusion.
        applyStimulus(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 10'd0, 2'b00, {5'd6, 5'd5});
        #1 checkOutput("fwd M prio", ForwardE1, 4'b0010);
        checkOutput("fwd M prio lat3", ForwardE3, 4'b0010);
        applyStimulus(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 10'd0, 2'b00, {5'd6, 5'd5});
        #1 checkOutput("fwd W", ForwardE1, 4'b0001);
        applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 10'd0, 2'b00, {5'd6, 5'd0});
        #1 checkOutput("fwd r0", ForwardE1, 4'b0000);
        applyStimulus(1'b0, 1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 10'd0, 2'b00, {5'd5, 5'd0});
        #1 checkOutput("fwd W op1", ForwardE1, 4'b0100);
        applyIdle();
        nextCycle();

        // Load-use on operand 1: one bubble for LOAD_LAT=1, three for LOAD_LAT=3.
        applyLoadUse(1'b0);
        #1 checkOutput("luse ctrl1", {StallF1, StallD1, FlushD1, FlushE1}, 4'b1101);
        checkOutput("luse ctrl3 c1", {StallF3, StallD3, FlushD3, FlushE3}, 4'b1101);
        checkOutput("luse cnt1 pre", stallCycles1, 0);
        nextCycle();
        applyIdle();
        #1 checkOutput("luse cnt1 post", stallCycles1, 1);
        checkOutput("luse ctrl1 done", {StallF1, StallD1, FlushD1, FlushE1}, 4'b0000);
        checkOutput("luse ctrl3 c2", {StallF3, StallD3, FlushD3, FlushE3}, 4'b1101);
        checkOutput("luse cnt3 c2", stallCycles3, 1);
        nextCycle();
        checkOutput("luse ctrl3 c3", {StallF3, StallD3, FlushD3, FlushE3}, 4'b1101);
        checkOutput("luse cnt3 c3", stallCycles3, 2);
        nextCycle();
        checkOutput("luse ctrl3 done", {StallF3, StallD3, FlushD3, FlushE3}, 4'b0000);
        checkOutput("luse cnt3 done", stallCycles3, 3);
        checkOutput("luse cnt1 hold", stallCycles1, 1);

        // Operand not used, or destination r0: no stall.
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, {5'd7, 5'd3}, 2'b01, 10'd0);
        #1 checkOutput("unused src", {StallF1, StallD1, FlushD1, FlushE1}, 4'b0000);
        checkOutput("unused src lat3", {StallF3, StallD3, FlushD3, FlushE3}, 4'b0000);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 10'd0, 2'b11, 10'd0);
        #1 checkOutput("rde r0", {StallF1, StallD1, FlushD1, FlushE1}, 4'b0000);
        applyIdle();
        nextCycle();

        // Branch in the second stall cycle aborts the sequence.
        applyLoadUse(1'b0);
        #1 checkOutput("abort c1", {StallF3, StallD3, FlushD3, FlushE3}, 4'b1101);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 10'd0, 2'b00, 10'd0);
        #1 checkOutput("abort flush3", {StallF3, StallD3, FlushD3, FlushE3}, 4'b0011);
        checkOutput("abort flush1", {StallF1, StallD1, FlushD1, FlushE1}, 4'b0011);
        checkOutput("abort cnt3", stallCycles3, 4);
        nextCycle();
        applyIdle();
        #1 checkOutput("abort idle", {StallF3, StallD3, FlushD3, FlushE3}, 4'b0000);
        checkOutput("abort cnt3 hold", stallCycles3, 4);
        checkOutput("abort cnt1", stallCycles1, 2);

        // Branch and load-use together in IDLE: flush only.
        applyLoadUse(1'b1);
        #1 checkOutput("br+luse 1", {StallF1, StallD1, FlushD1, FlushE1}, 4'b0011);
        checkOutput("br+luse 3", {StallF3, StallD3, FlushD3, FlushE3}, 4'b0011);
        nextCycle();
        applyIdle();
        #1 checkOutput("br+luse cnt1", stallCycles1, 2);
        checkOutput("br+luse cnt3", stallCycles3, 4);
        checkOutput("br+luse state3", {StallF3, StallD3, FlushD3, FlushE3}, 4'b0000);

        // 20 continuous stall cycles: 4-bit counter saturates at 15.
        applyLoadUse(1'b0);
        for (int i = 0; i < 13; i++) nextCycle();
        checkOutput("sat reach", stallCycles1, 15);
        for (int i = 0; i < 7; i++) nextCycle();
        checkOutput("sat hold", stallCycles1, 15);
        checkOutput("sat stall on", {StallF1, StallD1, FlushD1, FlushE1}, 4'b1101);
        checkOutput("sat cnt3", stallCycles3, 24);
        applyIdle();
        for (int i = 0; i < 4; i++) nextCycle();

        // Asynchronous reset between edges while in STALL.
        applyStimulus(1'b1, 1'b0, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, {5'd7, 5'd3}, 2'b10, {5'd0, 5'd5});
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 10'd0, 2'b00, {5'd0, 5'd5});
        #1 checkOutput("pre-rst stall", {StallF3, StallD3, FlushD3, FlushE3}, 4'b1101);
        checkOutput("pre-rst fwd", ForwardE3, 4'b0010);
        reset = 1'b0;
        #1 checkOutput("rst ctrl", {StallF3, StallD3, FlushD3, FlushE3}, 4'b0000);
        checkOutput("rst fwd", ForwardE3, 4'b0000);
        checkOutput("rst cnt3", stallCycles3, 0);
        checkOutput("rst cnt1", stallCycles1, 0);
        nextCycle();
        reset = 1'b1;
        #1 checkOutput("post-rst idle", {StallF3, StallD3, FlushD3, FlushE3}, 4'b0000);
        checkOutput("post-rst fwd", ForwardE3, 4'b0010);
        applyStimulus(1'b1, 1'b0, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, {5'd7, 5'd3}, 2'b10, {5'd0, 5'd5});
        #1 checkOutput("post-rst luse", {StallF3, StallD3, FlushD3, FlushE3}, 4'b1101);
        nextCycle();
        applyIdle();
        #1 checkOutput("post-rst c2", {StallF3, StallD3, FlushD3, FlushE3}, 4'b1101);
        checkOutput("post-rst cnt c2", stallCycles3, 1);
        nextCycle();
        nextCycle();
        checkOutput("post-rst done", {StallF3, StallD3, FlushD3, FlushE3}, 4'b0000);
        checkOutput("post-rst cnt", stallCycles3, 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
